div_iter: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage. It executes DIV and DIVU and writes {remainder, quotient} to HI/LO.
- Acts as the responder side of the div handshake: the hazard unit raises start_i (div_start) and holds the pipeline stalled until this block pulses ready_o (div_ready).
- ready_o and result_o are registered, so there is no combinational path from start_i to ready_o. This prevents a loop through the hazard unit.

---
 rtl/div_iter_pkg.sv | 18 +
 rtl/div_iter_if.sv | 35 +++
 rtl/div_iter_step.sv | 24 ++
 rtl/div_iter.sv | 121 ++++++++++++
 tb/tb_div_iter.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/div_iter_pkg.sv
// div_iter shared definitions: result-ready codes,
// DIV/DIVU function codes and FSM state encodings.
package div_iter_pkg;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [5:0] DIV_CONTROL  = 6'h1a;
  localparam logic [5:0] DIVU_CONTROL = 6'h1b;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// div handshake bundle between the hazard unit (master)
// and the iterative divider (slave).
interface div_iter_if #(
  parameter int WIDTH = 32
);

  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i,
    output annul_i,
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  start_i,
    input  annul_i,
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in the next
// dividend bit, trial-subtract, restore on borrow.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Trial needs one extra bit: 2*rem+1 can exceed WIDTH bits.
  always_comb begin
    trial    = {rem, dvd_msb};
    diff     = trial - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for EX,
// answering the hazard unit's div_start with a ready pulse.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  div_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_e state, state_n;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic             s1, s2, abort, last;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] rem_n, q_full;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             q_bit;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_n),
    .q_bit    (q_bit)
  );

  // Operand magnitudes, sign fix-up and abort decode.
  always_comb begin
    s1      = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    s2      = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1    = s1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2    = s2 ? -bus.opdata2_i : bus.opdata2_i;
    abort   = bus.annul_i | ~bus.start_i;
    last    = (cnt == CW'(WIDTH - 1));
    q_full  = {dvd[WIDTH-2:0], q_bit};
    quo_fix = sign_q ? -q_full : q_full;
    rem_fix = sign_r ? -rem_n : rem_n;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DivFree;
    else     state <= state_n;
  end

  // Next-state logic; annul wins over start everywhere.
  always_comb begin
    state_n = state;
    unique case (state)
      DivFree: begin
        if (bus.start_i && !bus.annul_i)
          state_n = (bus.opdata2_i == '0) ? DivByZero : DivOn;
      end
      DivByZero: state_n = abort ? DivFree : DivEnd;
      DivOn: begin
        if (abort)     state_n = DivFree;
        else if (last) state_n = DivEnd;
      end
      DivEnd:  state_n = DivFree;
      default: state_n = DivFree;
    endcase
  end

  // Datapath, registered result and one-cycle ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      bus.ready_o <= DivResultNotReady;
      unique case (state)
        DivFree: begin
          if (state_n == DivOn) begin
            dvd    <= abs1;
            dvs    <= abs2;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= s1 ^ s2;
            sign_r <= s1;
          end
        end
        DivByZero: begin
          if (state_n == DivEnd) begin
            bus.result_o <= '0;
            bus.ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (state_n != DivFree) begin
            rem <= rem_n;
            dvd <= q_full;
            cnt <= cnt + CW'(1);
          end
          if (state_n == DivEnd) begin
            bus.result_o <= {rem_fix, quo_fix};
            bus.ready_o  <= DivResultReady;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned
// results, divide-by-zero, annul, back-to-back and reset.
module tb_div_iter;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Caller is #1 after an edge with the DUT idle.
  task automatic run_div(input string tag,
                         input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int lat,
                         input logic [63:0] exp);
    int n;
    n = 0;
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        n = i;
        break;
      end
    end
    bus.start_i   = 1'b0;
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, bus.result_o, exp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 64'(bus.ready_o), 64'd0);
  endtask

  initial begin
    logic seen;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(bus.ready_o), 64'd0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33,
            {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33,
            {32'd1, 32'h7FFF_FFFC});

    seen = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h1234_5678;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (11) begin
      @(posedge clk);
      #1;
      seen |= bus.ready_o;
    end
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    seen |= bus.ready_o;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    seen |= bus.ready_o;
    chk("annul_noready", 64'(seen), 64'd0);
    chk("annul_hold", bus.result_o,
        {32'd1, 32'h7FFF_FFFC});
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33,
            {32'd0, 32'd3});

    run_div("divz_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0);

    run_div("div_min_m1", 1'b1, 32'h8000_0000,
            32'hFFFF_FFFF, 33,
            {32'd0, 32'h8000_0000});
    run_div("b2b_divu", 1'b0, 32'hFFFF_FFFF,
            32'h10, 33,
            {32'hF, 32'h0FFF_FFFF});

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd77;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    repeat (15) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(bus.ready_o), 64'd0);
    chk("arst_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_div("post_rst", 1'b0, 32'd1000, 32'd10, 33,
            {32'd0, 32'd100});
    run_div("div_0_5", 1'b1, 32'd0, 32'd5, 33,
            64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
